// File: rtl/pj_fe_be_queue.sv
// Multi-lane circular decoupling queue between front end and back end.
// Up to enq_width_p writes and deq_width_p FWFT reads per cycle; flush empties it.
module pj_fe_be_queue #(
  parameter int width_p       = 32,
  parameter int els_p         = 32,
  parameter int enq_width_p   = 2,
  parameter int deq_width_p   = 2,
  parameter int almost_full_p = 28
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               flush_i,
  input  logic                               enq_v_i,
  input  logic [$clog2(enq_width_p+1)-1:0]   enq_cnt_i,
  input  logic [enq_width_p*width_p-1:0]     enq_data_i,
  output logic                               enq_ready_o,
  output logic [deq_width_p-1:0]             deq_v_o,
  output logic [deq_width_p*width_p-1:0]     deq_data_o,
  input  logic [$clog2(deq_width_p+1)-1:0]   deq_yumi_cnt_i,
  output logic [$clog2(els_p+1)-1:0]         count_o,
  output logic                               empty_o,
  output logic                               full_o,
  output logic                               almost_full_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p+1);
  localparam int dcw   = $clog2(deq_width_p+1);

  logic [width_p-1:0] r_mem [els_p];
  logic [ptr_w-1:0]   r_head;
  logic [ptr_w-1:0]   r_tail;
  logic [cnt_w-1:0]   r_count;

  logic               w_enq_fire;
  logic [cnt_w-1:0]   w_enq_n;
  logic [cnt_w-1:0]   w_deq_n;

  // Ready looks only at registered occupancy, never at same-cycle dequeue
  assign enq_ready_o =
    (cnt_w'(els_p) - r_count) >= cnt_w'(enq_width_p);
  assign w_enq_fire  = enq_v_i & enq_ready_o;
  assign w_enq_n     = w_enq_fire ? cnt_w'(enq_cnt_i) : '0;
  assign w_deq_n     = cnt_w'(deq_yumi_cnt_i);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + ptr_w'(w_deq_n);
      r_tail  <= r_tail + ptr_w'(w_enq_n);
      r_count <= r_count + w_enq_n - w_deq_n;
    end
  end

  // Storage has no reset; pointer wrap is free since els_p is a power of two
  always_ff @(posedge clk_i) begin
    if (reset_n_i && !flush_i && w_enq_fire) begin
      for (int k = 0; k < enq_width_p; k++) begin
        if (k < int'(enq_cnt_i))
          r_mem[r_tail + ptr_w'(k)] <=
            enq_data_i[k*width_p +: width_p];
      end
    end
  end

  for (genvar k = 0; k < deq_width_p; k++) begin : g_deq
    assign deq_v_o[k] = r_count > cnt_w'(k);
    assign deq_data_o[k*width_p +: width_p] =
      r_mem[r_head + ptr_w'(k)];
  end

  assign count_o       = r_count;
  assign empty_o       = r_count == '0;
  assign full_o        = r_count == cnt_w'(els_p);
  assign almost_full_o = r_count >= cnt_w'(almost_full_p);

  a_yumi_legal: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (w_deq_n <= r_count) &&
    (deq_yumi_cnt_i <= dcw'(deq_width_p))
  );

endmodule

// File: tb/tb_pj_fe_be_queue.sv
// Bench for pj_fe_be_queue: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_pj_fe_be_queue;

  localparam int W   = 32;
  localparam int ELS = 32;
  localparam int AF  = 28;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          enq_v = 1'b0;
  logic [1:0]    enq_cnt = '0;
  logic [2*W-1:0] enq_data = '0;
  logic          enq_ready;
  logic [1:0]    deq_v;
  logic [2*W-1:0] deq_data;
  logic [1:0]    yumi = '0;
  logic [5:0]    count;
  logic          empty, full, afull;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;
  logic [W-1:0] mq[$];

  always #5 clk = ~clk;

  pj_fe_be_queue #(
    .width_p(W), .els_p(ELS), .enq_width_p(2),
    .deq_width_p(2), .almost_full_p(AF)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .enq_v_i(enq_v), .enq_cnt_i(enq_cnt), .enq_data_i(enq_data),
    .enq_ready_o(enq_ready), .deq_v_o(deq_v), .deq_data_o(deq_data),
    .deq_yumi_cnt_i(yumi), .count_o(count), .empty_o(empty),
    .full_o(full), .almost_full_o(afull)
  );

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("count", W'(count), W'(n));
    chk("empty", W'(empty), W'(n == 0));
    chk("full", W'(full), W'(n == ELS));
    chk("afull", W'(afull), W'(n >= AF));
    chk("ready", W'(enq_ready), W'(ELS - n >= 2));
    for (int k = 0; k < 2; k++) begin
      chk("deq_v", W'(deq_v[k]), W'(n > k));
      if (n > k) chk("deq_data", deq_data[k*W +: W], mq[k]);
    end
  endtask

  // One clock: check current outputs, drive inputs, advance the model
  task automatic cyc(input bit rn, input bit fl, input bit ev,
                     input int ec, input logic [W-1:0] d0,
                     input logic [W-1:0] d1, input int yc);
    bit rdy;
    @(negedge clk);
    if (chk_on) check_all();
    reset_n  = rn;
    flush    = fl;
    enq_v    = ev;
    enq_cnt  = 2'(ec);
    enq_data = {d1, d0};
    yumi     = 2'(yc);
    if (!rn) begin
      mq.delete();
      chk_on = 1;
    end else if (fl) begin
      mq.delete();
    end else begin
      rdy = (ELS - mq.size()) >= 2;
      repeat (yc) void'(mq.pop_front());
      if (ev && rdy) begin
        if (ec >= 1) mq.push_back(d0);
        if (ec >= 2) mq.push_back(d1);
      end
    end
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1, 0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    int tag;
    int sz, ym, ec;
    cyc(0, 0, 0, 0, '0, '0, 0);
    cyc(0, 0, 0, 0, '0, '0, 0);
    peek();
    chk("rst_count", W'(count), 0);
    chk("rst_deq_v", W'(deq_v), 0);
    idle(3);

    // Fill to full, then an extra request while full
    tag = 16'h100;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 1, 2, W'(tag), W'(tag + 1), 0);
      tag += 2;
    end
    peek();
    chk("fill_full", W'(full), 1);
    chk("fill_ready", W'(enq_ready), 0);
    cyc(1, 0, 1, 2, 32'hDEAD, 32'hBEEF, 0);
    peek();
    chk("full_hold", W'(count), 32);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, '0, '0, 2);

    // Ordering / first-word fall-through
    cyc(1, 0, 1, 2, 32'h1, 32'h2, 0);
    peek();
    chk("ord_v", W'(deq_v), 3);
    chk("ord_l0", deq_data[W-1:0], 32'h1);
    chk("ord_l1", deq_data[2*W-1:W], 32'h2);
    cyc(1, 0, 0, 0, '0, '0, 1);
    peek();
    chk("ord_pop_l0", deq_data[W-1:0], 32'h2);
    chk("ord_pop_v", W'(deq_v), 1);
    cyc(1, 0, 0, 0, '0, '0, 1);

    // Wrap: pointers to 30, then straddle slot 31 -> 0
    cyc(1, 1, 0, 0, '0, '0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 0, 1, 2, W'(i), W'(i + 50), 0);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, '0, '0, 2);
    cyc(1, 0, 1, 2, 32'hA, 32'hB, 0);
    cyc(1, 0, 1, 2, 32'hC, 32'hD, 0);
    peek();
    chk("wrap_l0", deq_data[W-1:0], 32'hA);
    chk("wrap_l1", deq_data[2*W-1:W], 32'hB);
    cyc(1, 0, 0, 0, '0, '0, 2);
    peek();
    chk("wrap_l2", deq_data[W-1:0], 32'hC);
    chk("wrap_l3", deq_data[2*W-1:W], 32'hD);
    cyc(1, 0, 0, 0, '0, '0, 2);

    // Simultaneous enqueue/dequeue at count 5
    cyc(1, 0, 1, 2, 32'h21, 32'h22, 0);
    cyc(1, 0, 1, 2, 32'h23, 32'h24, 0);
    cyc(1, 0, 1, 1, 32'h25, 32'h0, 0);
    cyc(1, 0, 1, 2, 32'h26, 32'h27, 2);
    peek();
    chk("simul_count", W'(count), 5);
    chk("simul_l0", deq_data[W-1:0], 32'h23);

    // Flush mid-stream at count 12
    cyc(1, 0, 1, 2, 32'h28, 32'h29, 0);
    cyc(1, 0, 1, 2, 32'h2A, 32'h2B, 0);
    cyc(1, 0, 1, 2, 32'h2C, 32'h2D, 0);
    cyc(1, 0, 1, 1, 32'h2E, 32'h0, 0);
    peek();
    chk("pre_flush", W'(count), 12);
    cyc(1, 1, 1, 2, 32'h77, 32'h78, 1);
    peek();
    chk("flush_count", W'(count), 0);
    chk("flush_empty", W'(empty), 1);
    chk("flush_v", W'(deq_v), 0);
    cyc(1, 1, 0, 0, '0, '0, 0);
    cyc(1, 0, 1, 1, 32'h55, 32'h0, 0);
    peek();
    chk("post_flush_l0", deq_data[W-1:0], 32'h55);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      sz = mq.size();
      ym = $urandom_range(0, (sz < 2) ? sz : 2);
      ec = $urandom_range(0, 2);
      if ($urandom_range(0, 299) == 0)
        cyc(0, 0, 0, 0, '0, '0, 0);
      else if ($urandom_range(0, 39) == 0)
        cyc(1, 1, 1, ec, $urandom, $urandom, ym);
      else
        cyc(1, 0, $urandom_range(0, 3) != 0, ec,
            $urandom, $urandom, ($urandom_range(0, 2) == 0) ? 0 : ym);
    end
    cyc(1, 0, 0, 0, '0, '0, 0);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
